// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arbiter
// Purpose  : Shares one fully pipelined IEEE-754 single-precision multiplier
//            between two requesters. Grants are round-robin. A tag pipeline
//            follows each accepted operation through the multiplier, so every
//            response goes back to the requester that issued it. Responses
//            come back in acceptance order. Per-requester sticky flag
//            registers accumulate the exception flags.
// Ports    : clk, rst (async, active-low)
//            req_valid[1:0] / req_ready[1:0]      - request handshake
//            req_a0, req_b0, req_a1, req_b1       - operand pairs
//            mul_a, mul_b                         - registered operands out
//            mul_result, mul_flags                - multiplier return path
//            rsp_valid[1:0], rsp_result, rsp_flags- registered response
//            sticky0, sticky1, clr_sticky         - accumulated flags
//            busy                                 - work in flight
// Revision : 1.0  initial release
// ============================================================================
module fp_mul_arbiter #(
    parameter int MUL_LAT = 2  // multiplier latency in cycles, legal 1..8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic [3:0]  mul_flags,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  sticky0,
    output logic [3:0]  sticky1,
    input  logic        clr_sticky,
    output logic        busy
);

    logic               rr_ptr;
    logic               accept;
    logic               grant_id;
    logic [MUL_LAT:0]   tag_valid;
    logic [MUL_LAT:0]   tag_id;

    // Grant selection. The pointer only matters when both requesters
    // contend. Nothing is granted while reset is held, so an operation
    // cannot be accepted in the same cycle the pipeline is being flushed.
    always_comb begin
        req_ready = 2'b00;
        if (rst) begin
            if (req_valid == 2'b11) begin
                req_ready = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                req_ready = req_valid;
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign grant_id = req_ready[1];

    // tag_valid[k] / tag_id[k] describe the operation whose operands were
    // presented to the multiplier k cycles ago. Stage MUL_LAT therefore lines
    // up with mul_result/mul_flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[MUL_LAT-1:0], accept};
            tag_id    <= {tag_id[MUL_LAT-1:0], grant_id};
            if (accept) begin
                rr_ptr <= ~grant_id;
                mul_a  <= grant_id ? req_a1 : req_a0;
                mul_b  <= grant_id ? req_b1 : req_b0;
            end
        end
    end

    // Response stage. Result and flags are captured only for a real
    // operation, so they hold the last response between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid  <= 2'b00;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
        end else begin
            rsp_valid <= 2'b00;
            if (tag_valid[MUL_LAT]) begin
                rsp_valid  <= tag_id[MUL_LAT] ? 2'b10 : 2'b01;
                rsp_result <= mul_result;
                rsp_flags  <= mul_flags;
            end
        end
    end

    // Sticky flags. The clear is applied before the OR-in, so flags that
    // arrive in the same cycle as a clear are kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky0 <= 4'd0;
            sticky1 <= 4'd0;
        end else begin
            sticky0 <= (clr_sticky ? 4'd0 : sticky0) |
                       (rsp_valid[0] ? rsp_flags : 4'd0);
            sticky1 <= (clr_sticky ? 4'd0 : sticky1) |
                       (rsp_valid[1] ? rsp_flags : 4'd0);
        end
    end

    assign busy = (|tag_valid) | (|rsp_valid);

endmodule
`default_nettype wire

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 MUL_LAT, 2, cycles from mul_a/mul_b launch to valid mul_result/mul_flags; legal 1..8.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  bit i: requester i presents an operand pair.
REQ-005 req_ready  output  2  bit i: requester i operands accepted this cycle.
REQ-006 req_a0, req_b0  input  32 each  requester 0 IEEE-754 single operands.
REQ-007 req_a1, req_b1  input  32 each  requester 1 IEEE-754 single operands.
REQ-008 mul_a, mul_b  output  32 each  registered operands to the shared fp_multiplier.
REQ-009 mul_result  input  32  product from the shared fp_multiplier.
REQ-010 mul_flags  input  4  {nan, inf, underflow, overflow} from the shared fp_multiplier.
REQ-011 rsp_valid  output  2  bit i: one-cycle pulse, response for requester i.
REQ-012 rsp_result, rsp_flags  output  32, 4  registered product and flags for the pulsed requester.
REQ-013 sticky0, sticky1  output  4 each  per-requester OR of all returned flags.
REQ-014 clr_sticky  input  1  clears both sticky registers.
REQ-015 busy  output  1  any operation in flight or response pending.

Function
REQ-016 At most one req_ready bit shall be high per cycle; acceptance = req_valid[i] & req_ready[i].
REQ-017 req_ready shall be combinational: only one valid -> that requester; both valid -> requester named by rr_ptr; none -> 2'b00.
REQ-018 rr_ptr (1 bit) shall be set to the non-granted index after every acceptance and hold otherwise; no requester starves.
REQ-019 One acceptance per cycle, no bubbles; the multiplier is treated as fully pipelined.
REQ-020 Operands accepted at edge T shall appear on mul_a/mul_b from cycle T+1; mul_a/mul_b hold their last value when nothing is accepted.
REQ-021 A tag pipeline (valid bit + requester id) of depth MUL_LAT+1 shall track every accepted operation.
REQ-022 mul_result/mul_flags shall be sampled in cycle T+1+MUL_LAT and registered; rsp_valid[id] pulses in cycle T+2+MUL_LAT (total latency MUL_LAT+2).
REQ-023 Responses shall return in acceptance order, one per cycle max; rsp_result/rsp_flags hold the last value when rsp_valid=0.
REQ-024 On each response, sticky[id] |= rsp_flags; clr_sticky in the same cycle as a response: clear first, then set the new flags (new flags survive).
REQ-025 busy = OR of tag-pipeline valid bits and rsp_valid.
REQ-026 Requesters shall hold operands stable while req_valid=1 and req_ready=0; the block does not buffer unaccepted requests.

Reset
REQ-027 rst=0 shall immediately force rsp_valid=0, rsp_result=0, rsp_flags=0, mul_a=0, mul_b=0, sticky0=sticky1=0, rr_ptr=0, all tags invalid, busy=0.
REQ-028 req_ready shall be 2'b00 while rst=0.
REQ-029 Operations in flight when reset asserts shall be discarded; no rsp_valid pulse for them after release.

Verification
REQ-030 MUL_LAT=2, req0 0x40000000 x 0x40400000, model returns 0x40C00000 -> rsp_valid=2'b01 exactly 4 cycles after acceptance, rsp_result=0x40C00000, rsp_flags=0.
REQ-031 Both requesters valid for 4 consecutive cycles from reset -> grants 0,1,0,1; rsp_valid pulses 01,10,01,10 on consecutive cycles.
REQ-032 req1 0x7F7FFFFF x 0x7F7FFFFF, model overflow=1 -> rsp_flags=4'b0001 with rsp_valid=2'b10, sticky1=4'b0001, sticky0=0; clr_sticky one cycle later -> both 0.
REQ-033 req0 0x7FC00000 x 0x40000000, model nan=1, clr_sticky asserted in the response cycle -> sticky0=4'b1000 afterwards.
REQ-034 rst=0 with two operations in flight -> all outputs 0 asynchronously; after release no rsp_valid pulse, busy=0, first contended grant goes to requester 0.
